// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scan, PWM dimming,
// frame-synchronous double-buffered display data and registered active-low outputs.
module sseg_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [4*NDIG-1:0]   hex_in,
    input  logic [8*NDIG-1:0]   raw_in,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     blank_in,
    input  logic                raw_mode,
    input  logic [3:0]          bright,
    output logic [NDIG-1:0]     an,
    output logic [7:0]          sseg,
    output logic                frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(NDIG);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] ILAST = IW'(NDIG - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          pwm_q, pwm_d;
    logic                pend_q, pend_d;
    logic [4*NDIG-1:0]   pnd_hex_q, pnd_hex_d, hex_q, hex_d;
    logic [8*NDIG-1:0]   pnd_raw_q, pnd_raw_d, raw_q, raw_d;
    logic [NDIG-1:0]     pnd_dp_q, pnd_dp_d, dp_q, dp_d;
    logic [NDIG-1:0]     pnd_blank_q, pnd_blank_d, blank_q, blank_d;
    logic                pnd_rawm_q, pnd_rawm_d, rawm_q, rawm_d;
    logic [NDIG-1:0]     an_q, an_d;
    logic [7:0]          sseg_q, sseg_d;
    logic                fd_q, fd_d;
    logic                tick, wrap, lit;

    logic [3:0] hex_dig [NDIG];
    logic [7:0] raw_dig [NDIG];

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        assign hex_dig[gi] = hex_q[4*gi +: 4];
        assign raw_dig[gi] = raw_q[8*gi +: 8];
    end

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick        = (presc_q == PLAST);
        wrap        = tick && (idx_q == ILAST);
        presc_d     = tick ? '0 : presc_q + PW'(1);
        idx_d       = idx_q;
        if (tick) idx_d = (idx_q == ILAST) ? '0 : idx_q + IW'(1);
        pwm_d       = (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
        fd_d        = wrap;

        pend_d      = pend_q;
        pnd_hex_d   = pnd_hex_q;
        pnd_raw_d   = pnd_raw_q;
        pnd_dp_d    = pnd_dp_q;
        pnd_blank_d = pnd_blank_q;
        pnd_rawm_d  = pnd_rawm_q;
        hex_d       = hex_q;
        raw_d       = raw_q;
        dp_d        = dp_q;
        blank_d     = blank_q;
        rawm_d      = rawm_q;

        if (load) begin
            pend_d      = 1'b1;
            pnd_hex_d   = hex_in;
            pnd_raw_d   = raw_in;
            pnd_dp_d    = dp_in;
            pnd_blank_d = blank_in;
            pnd_rawm_d  = raw_mode;
        end
        // A load landing on the wrap tick bypasses the buffer so it is shown this frame.
        if (wrap) begin
            pend_d = 1'b0;
            if (load) begin
                hex_d   = hex_in;
                raw_d   = raw_in;
                dp_d    = dp_in;
                blank_d = blank_in;
                rawm_d  = raw_mode;
            end else if (pend_q) begin
                hex_d   = pnd_hex_q;
                raw_d   = pnd_raw_q;
                dp_d    = pnd_dp_q;
                blank_d = pnd_blank_q;
                rawm_d  = pnd_rawm_q;
            end
        end

        lit    = (presc_q != '0) && !blank_q[idx_q] && (pwm_q < bright);
        an_d   = '1;
        sseg_d = 8'hFF;
        if (lit) begin
            an_d   = ~(NDIG'(1) << idx_q);
            sseg_d = rawm_q ? raw_dig[idx_q] : {~dp_q[idx_q], hex7(hex_dig[idx_q])};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            pend_q      <= 1'b0;
            pnd_hex_q   <= '0;
            pnd_raw_q   <= '1;
            pnd_dp_q    <= '0;
            pnd_blank_q <= '1;
            pnd_rawm_q  <= 1'b0;
            hex_q       <= '0;
            raw_q       <= '1;
            dp_q        <= '0;
            blank_q     <= '1;
            rawm_q      <= 1'b0;
            an_q        <= '1;
            sseg_q      <= 8'hFF;
            fd_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            pend_q      <= pend_d;
            pnd_hex_q   <= pnd_hex_d;
            pnd_raw_q   <= pnd_raw_d;
            pnd_dp_q    <= pnd_dp_d;
            pnd_blank_q <= pnd_blank_d;
            pnd_rawm_q  <= pnd_rawm_d;
            hex_q       <= hex_d;
            raw_q       <= raw_d;
            dp_q        <= dp_d;
            blank_q     <= blank_d;
            rawm_q      <= rawm_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
            fd_q        <= fd_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_done = fd_q;

endmodule
